// File: rtl/uart_tx_fifo_if.sv
// Byte write handshake from the unpacker and start/busy/done handshake to the
// UART serializer. The FIFO sits on the slave side of both.
interface uart_tx_fifo_if;
  logic       wr;
  logic [7:0] wr_data;
  logic       wr_rdy;
  logic       uart_we;
  logic [7:0] uart_tx_data;
  logic       uart_tx_busy;
  logic       uart_tx_done;

  modport slave (
    input  wr, wr_data, uart_tx_busy, uart_tx_done,
    output wr_rdy, uart_we, uart_tx_data
  );

  modport master (
    output wr, wr_data, uart_tx_busy, uart_tx_done,
    input  wr_rdy, uart_we, uart_tx_data
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Transmit byte buffer: 2^N-deep FIFO feeding a UART serializer one byte at a
// time, with optional CTS gating of each byte launch.
module uart_tx_fifo #(
  parameter int LOG2_TX_BUFFER_LEN = 4
) (
  input  logic                        ifclk,
  input  logic                        resetb,
  uart_tx_fifo_if.slave               bus,
  input  logic                        clear_tx_buffer,
  input  logic                        cts_en,
  input  logic                        cts_n,
  output logic [LOG2_TX_BUFFER_LEN:0] tx_level,
  output logic                        tx_empty,
  output logic                        tx_overflow
);
  localparam int         N     = LOG2_TX_BUFFER_LEN;
  localparam int         D     = 1 << N;
  localparam logic [N:0] DEPTH = {1'b1, {N{1'b0}}};

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

  state_e       state_q, state_d;
  logic [N-1:0] rp_q, rp_d;
  logic [N-1:0] wp_q, wp_d;
  logic [N:0]   count_q, count_d;
  logic         ovf_q, ovf_d;
  logic         uart_we_q, uart_we_d;
  logic [7:0]   tx_data_q, tx_data_d;
  logic         tx_empty_q, tx_empty_d;
  logic         ready_q, ready_d;
  logic         cts_s1_q, cts_s1_d;
  logic         cts_s2_q, cts_s2_d;
  logic [7:0]   mem_q [D];

  logic full, empty, cts_ok, push, launch;

  assign full   = (count_q == DEPTH);
  assign empty  = (count_q == '0);
  assign cts_ok = !cts_en || !cts_s2_q;
  assign push   = bus.wr && !full && !clear_tx_buffer;
  // A byte must have been queued for a full cycle before it can launch, so a
  // write into an idle buffer reaches the serializer two clocks later.
  assign launch = (state_q == IDLE) && !empty && ready_q && !bus.uart_tx_busy &&
                  cts_ok && !clear_tx_buffer;

  assign cts_s1_d = cts_n;
  assign cts_s2_d = cts_s1_q;
  assign ready_d  = !empty;

  always_comb begin
    state_d   = state_q;
    rp_d      = rp_q;
    wp_d      = wp_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    uart_we_d = 1'b0;
    tx_data_d = tx_data_q;

    if (clear_tx_buffer) begin
      rp_d    = '0;
      wp_d    = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if (bus.wr && full) ovf_d = 1'b1;
      if (push) wp_d = wp_q + 1'b1;
      if (launch) begin
        rp_d      = rp_q + 1'b1;
        tx_data_d = mem_q[rp_q];
        uart_we_d = 1'b1;
      end
      if (push && !launch)      count_d = count_q + 1'b1;
      else if (!push && launch) count_d = count_q - 1'b1;
    end

    // SEND only waits for the serializer; a flush does not abort the byte.
    if (state_q == IDLE) begin
      if (launch) state_d = SEND;
    end else begin
      if (bus.uart_tx_done) state_d = IDLE;
    end

    tx_empty_d = (count_d == '0) && (state_d == IDLE);
  end

  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      state_q    <= IDLE;
      rp_q       <= '0;
      wp_q       <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      uart_we_q  <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_empty_q <= 1'b1;
      ready_q    <= 1'b0;
      cts_s1_q   <= 1'b1;
      cts_s2_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      rp_q       <= rp_d;
      wp_q       <= wp_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      uart_we_q  <= uart_we_d;
      tx_data_q  <= tx_data_d;
      tx_empty_q <= tx_empty_d;
      ready_q    <= ready_d;
      cts_s1_q   <= cts_s1_d;
      cts_s2_q   <= cts_s2_d;
    end
  end

  // Storage carries no reset; only slots behind the write pointer are read.
  always_ff @(posedge ifclk) begin
    if (push) mem_q[wp_q] <= bus.wr_data;
  end

  assign bus.wr_rdy       = !full;
  assign bus.uart_we      = uart_we_q;
  assign bus.uart_tx_data = tx_data_q;
  assign tx_level         = count_q;
  assign tx_empty         = tx_empty_q;
  assign tx_overflow      = ovf_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a serializer model with random byte times records
// every launched byte; each scenario compares against an expected byte queue.
module tb_uart_tx_fifo;
  localparam int N = 4;
  localparam int D = 1 << N;

  logic       ifclk = 1'b0;
  logic       resetb = 1'b1;
  logic       clear_tx_buffer = 1'b0;
  logic       cts_en = 1'b0;
  logic       cts_n = 1'b1;
  logic [N:0] tx_level;
  logic       tx_empty;
  logic       tx_overflow;

  uart_tx_fifo_if bus();

  uart_tx_fifo #(.LOG2_TX_BUFFER_LEN(N)) dut (
    .ifclk(ifclk),
    .resetb(resetb),
    .bus(bus),
    .clear_tx_buffer(clear_tx_buffer),
    .cts_en(cts_en),
    .cts_n(cts_n),
    .tx_level(tx_level),
    .tx_empty(tx_empty),
    .tx_overflow(tx_overflow)
  );

  always #5 ifclk = ~ifclk;

  int total = 0;
  int bad = 0;

  // Serializer model: busy for 3..8 cycles per byte, done pulse at the end.
  logic        hold_busy = 1'b0;
  int unsigned tx_cnt;
  int          we_cnt = 0;
  int          proto_bad = 0;
  logic        prev_we, prev_busy;
  logic [7:0]  sent_q[$];
  logic [7:0]  exp_q[$];

  assign bus.uart_tx_busy = hold_busy || (tx_cnt != 0);

  always @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      tx_cnt           <= 0;
      bus.uart_tx_done <= 1'b0;
      prev_we          <= 1'b0;
      prev_busy        <= 1'b0;
    end else begin
      bus.uart_tx_done <= 1'b0;
      prev_we          <= bus.uart_we;
      prev_busy        <= bus.uart_tx_busy;
      if (bus.uart_we) begin
        if (prev_we || prev_busy) proto_bad <= proto_bad + 1;
        sent_q.push_back(bus.uart_tx_data);
        we_cnt <= we_cnt + 1;
        tx_cnt <= $urandom_range(8, 3);
      end else if (tx_cnt == 1) begin
        tx_cnt           <= 0;
        bus.uart_tx_done <= 1'b1;
      end else if (tx_cnt != 0) begin
        tx_cnt <= tx_cnt - 1;
      end
    end
  end

  // -1: serial output equals exp_q; -2: length differs; else first bad index.
  function automatic int order_err();
    if (sent_q.size() != exp_q.size()) return -2;
    foreach (exp_q[i]) if (sent_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  // All tasks start and end just after a falling edge.
  task automatic do_write(input logic [7:0] b);
    bus.wr = 1'b1;
    bus.wr_data = b;
    @(negedge ifclk);
    bus.wr = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge ifclk);
      if (bus.uart_tx_done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_drain(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge ifclk);
      if (we_cnt >= target && tx_empty === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    #2 resetb = 1'b0;
    #1;
    total++; if (bus.uart_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%0b exp=0", bus.uart_we); end
    total++; if (bus.uart_tx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%0h exp=0", bus.uart_tx_data); end
    total++; if (tx_level !== '0) begin bad++; $display("FAIL reset_level got=%0d exp=0", tx_level); end
    total++; if (tx_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%0b exp=1", tx_empty); end
    total++; if (tx_overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b exp=0", tx_overflow); end
    total++; if (bus.wr_rdy !== 1'b1) begin bad++; $display("FAIL reset_wr_rdy got=%0b exp=1", bus.wr_rdy); end
    @(negedge ifclk);
    resetb = 1'b1;
    repeat (3) @(negedge ifclk);
    total++; if (bus.uart_we !== 1'b0 || tx_empty !== 1'b1) begin
      bad++; $display("FAIL reset_idle we=%0b empty=%0b exp we=0 empty=1", bus.uart_we, tx_empty);
    end
  endtask

  task automatic test_single();
    int base;
    bit ok;
    base = we_cnt;
    sent_q.delete();
    do_write(8'hA5);
    total++; if (bus.uart_we !== 1'b0) begin bad++; $display("FAIL single_e0 we=%0b exp=0", bus.uart_we); end
    @(negedge ifclk);
    total++; if (bus.uart_we !== 1'b0) begin bad++; $display("FAIL single_e1 we=%0b exp=0", bus.uart_we); end
    @(negedge ifclk);
    total++; if (bus.uart_we !== 1'b1 || bus.uart_tx_data !== 8'hA5) begin
      bad++; $display("FAIL single_launch we=%0b data=%0h exp we=1 data=a5", bus.uart_we, bus.uart_tx_data);
    end
    @(negedge ifclk);
    total++; if (bus.uart_we !== 1'b0 || bus.uart_tx_data !== 8'hA5) begin
      bad++; $display("FAIL single_pulse we=%0b data=%0h exp we=0 data=a5", bus.uart_we, bus.uart_tx_data);
    end
    wait_done(ok);
    total++; if (!ok) begin bad++; $display("FAIL single_done_timeout got=0 exp=1"); end
    @(negedge ifclk);
    total++; if (tx_empty !== 1'b1) begin bad++; $display("FAIL single_empty got=%0b exp=1", tx_empty); end
    total++; if (we_cnt - base !== 1) begin bad++; $display("FAIL single_count got=%0d exp=1", we_cnt - base); end
  endtask

  task automatic test_fill_order();
    int base, e;
    bit ok;
    base = we_cnt;
    sent_q.delete();
    exp_q.delete();
    hold_busy = 1'b1;
    for (int i = 0; i < D; i++) begin
      exp_q.push_back(8'(i));
      do_write(8'(i));
    end
    total++; if (bus.wr_rdy !== 1'b0) begin bad++; $display("FAIL fill_wr_rdy got=%0b exp=0", bus.wr_rdy); end
    total++; if (tx_level !== 5'(D)) begin bad++; $display("FAIL fill_level got=%0d exp=%0d", tx_level, D); end
    total++; if (we_cnt !== base) begin bad++; $display("FAIL fill_held got=%0d exp=0", we_cnt - base); end
    hold_busy = 1'b0;
    wait_drain(base + D, ok);
    total++; if (!ok) begin bad++; $display("FAIL fill_drain_timeout got=%0d exp=%0d", we_cnt - base, D); end
    repeat (10) @(negedge ifclk);
    total++; if (we_cnt - base !== D) begin bad++; $display("FAIL fill_pulses got=%0d exp=%0d", we_cnt - base, D); end
    e = order_err();
    total++; if (e !== -1) begin bad++; $display("FAIL fill_order err=%0d exp=-1", e); end
  endtask

  task automatic test_overflow_clear();
    int base;
    base = we_cnt;
    hold_busy = 1'b1;
    for (int i = 0; i < D; i++) do_write(8'($urandom));
    total++; if (tx_overflow !== 1'b0) begin bad++; $display("FAIL ovf_early got=%0b exp=0", tx_overflow); end
    do_write(8'($urandom));
    total++; if (tx_overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%0b exp=1", tx_overflow); end
    total++; if (tx_level !== 5'(D)) begin bad++; $display("FAIL ovf_level got=%0d exp=%0d", tx_level, D); end
    clear_tx_buffer = 1'b1;
    do_write(8'($urandom));
    clear_tx_buffer = 1'b0;
    total++; if (tx_level !== '0) begin bad++; $display("FAIL clear_level got=%0d exp=0", tx_level); end
    total++; if (tx_overflow !== 1'b0) begin bad++; $display("FAIL clear_ovf got=%0b exp=0", tx_overflow); end
    total++; if (tx_empty !== 1'b1 || bus.wr_rdy !== 1'b1) begin
      bad++; $display("FAIL clear_flags empty=%0b wr_rdy=%0b exp 1 1", tx_empty, bus.wr_rdy);
    end
    hold_busy = 1'b0;
    repeat (20) @(negedge ifclk);
    total++; if (we_cnt !== base) begin bad++; $display("FAIL clear_no_tx got=%0d exp=0", we_cnt - base); end
  endtask

  task automatic test_push_pop_full();
    int base, e;
    bit ok;
    logic [7:0] b;
    base = we_cnt;
    sent_q.delete();
    exp_q.delete();
    hold_busy = 1'b1;
    for (int i = 0; i < D; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      do_write(b);
    end
    hold_busy = 1'b0;
    do_write(8'($urandom));
    total++; if (tx_overflow !== 1'b1) begin bad++; $display("FAIL pp_full_ovf got=%0b exp=1", tx_overflow); end
    total++; if (tx_level !== 5'(D - 1)) begin bad++; $display("FAIL pp_full_level got=%0d exp=%0d", tx_level, D - 1); end
    total++; if (bus.uart_we !== 1'b1 || bus.uart_tx_data !== exp_q[0]) begin
      bad++; $display("FAIL pp_full_launch we=%0b data=%0h exp we=1 data=%0h", bus.uart_we, bus.uart_tx_data, exp_q[0]);
    end
    wait_done(ok);
    total++; if (!ok) begin bad++; $display("FAIL pp_done_timeout got=0 exp=1"); end
    @(negedge ifclk);
    b = 8'($urandom);
    exp_q.push_back(b);
    do_write(b);
    total++; if (tx_level !== 5'(D - 1)) begin bad++; $display("FAIL pp_level got=%0d exp=%0d", tx_level, D - 1); end
    total++; if (bus.uart_we !== 1'b1 || bus.uart_tx_data !== exp_q[1]) begin
      bad++; $display("FAIL pp_launch we=%0b data=%0h exp we=1 data=%0h", bus.uart_we, bus.uart_tx_data, exp_q[1]);
    end
    wait_drain(base + D + 1, ok);
    total++; if (!ok) begin bad++; $display("FAIL pp_drain_timeout got=%0d exp=%0d", we_cnt - base, D + 1); end
    e = order_err();
    total++; if (e !== -1) begin bad++; $display("FAIL pp_order err=%0d exp=-1", e); end
    clear_tx_buffer = 1'b1;
    @(negedge ifclk);
    clear_tx_buffer = 1'b0;
  endtask

  task automatic test_cts();
    int base, e;
    bit ok;
    logic [7:0] b;
    cts_en = 1'b1;
    cts_n = 1'b1;
    repeat (3) @(negedge ifclk);
    base = we_cnt;
    sent_q.delete();
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      do_write(b);
    end
    repeat (10) @(negedge ifclk);
    total++; if (we_cnt !== base) begin bad++; $display("FAIL cts_blocked got=%0d exp=0", we_cnt - base); end
    total++; if (tx_level !== 5'd3) begin bad++; $display("FAIL cts_level got=%0d exp=3", tx_level); end
    cts_n = 1'b0;
    @(negedge ifclk);
    total++; if (bus.uart_we !== 1'b0) begin bad++; $display("FAIL cts_lat1 we=%0b exp=0", bus.uart_we); end
    @(negedge ifclk);
    total++; if (bus.uart_we !== 1'b0) begin bad++; $display("FAIL cts_lat2 we=%0b exp=0", bus.uart_we); end
    @(negedge ifclk);
    total++; if (bus.uart_we !== 1'b1 || bus.uart_tx_data !== exp_q[0]) begin
      bad++; $display("FAIL cts_launch we=%0b data=%0h exp we=1 data=%0h", bus.uart_we, bus.uart_tx_data, exp_q[0]);
    end
    cts_n = 1'b1;
    wait_done(ok);
    total++; if (!ok) begin bad++; $display("FAIL cts_done_timeout got=0 exp=1"); end
    repeat (20) @(negedge ifclk);
    total++; if (we_cnt - base !== 1) begin bad++; $display("FAIL cts_hold got=%0d exp=1", we_cnt - base); end
    total++; if (tx_level !== 5'd2) begin bad++; $display("FAIL cts_hold_level got=%0d exp=2", tx_level); end
    cts_n = 1'b0;
    wait_drain(base + 3, ok);
    total++; if (!ok) begin bad++; $display("FAIL cts_drain_timeout got=%0d exp=3", we_cnt - base); end
    e = order_err();
    total++; if (e !== -1) begin bad++; $display("FAIL cts_order err=%0d exp=-1", e); end
    cts_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    int base, e;
    bit ok;
    logic [7:0] b;
    for (int i = 0; i < 6; i++) do_write(8'($urandom));
    total++; if (tx_level !== 5'd5 || tx_empty !== 1'b0) begin
      bad++; $display("FAIL rst_mid_pre level=%0d empty=%0b exp 5 0", tx_level, tx_empty);
    end
    #2 resetb = 1'b0;
    #1;
    total++; if (bus.uart_we !== 1'b0 || bus.uart_tx_data !== 8'h00 || bus.wr_rdy !== 1'b1) begin
      bad++; $display("FAIL rst_mid_bus we=%0b data=%0h wr_rdy=%0b exp 0 0 1", bus.uart_we, bus.uart_tx_data, bus.wr_rdy);
    end
    total++; if (tx_level !== '0 || tx_empty !== 1'b1 || tx_overflow !== 1'b0) begin
      bad++; $display("FAIL rst_mid_status level=%0d empty=%0b ovf=%0b exp 0 1 0", tx_level, tx_empty, tx_overflow);
    end
    @(negedge ifclk);
    resetb = 1'b1;
    base = we_cnt;
    repeat (20) @(negedge ifclk);
    total++; if (we_cnt !== base) begin bad++; $display("FAIL rst_mid_quiet got=%0d exp=0", we_cnt - base); end
    sent_q.delete();
    exp_q.delete();
    b = 8'($urandom);
    exp_q.push_back(b);
    do_write(b);
    @(negedge ifclk);
    @(negedge ifclk);
    total++; if (bus.uart_we !== 1'b1 || bus.uart_tx_data !== b) begin
      bad++; $display("FAIL rst_mid_relaunch we=%0b data=%0h exp we=1 data=%0h", bus.uart_we, bus.uart_tx_data, b);
    end
    wait_drain(base + 1, ok);
    e = order_err();
    total++; if (!ok || e !== -1) begin bad++; $display("FAIL rst_mid_order ok=%0b err=%0d exp 1 -1", ok, e); end
  endtask

  task automatic test_random_stream();
    int base, acc, e;
    bit ok;
    logic [7:0] b;
    base = we_cnt;
    acc = 0;
    sent_q.delete();
    exp_q.delete();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(2, 0) != 0 && (acc - (we_cnt - base)) < D) begin
        b = 8'($urandom);
        total++; if (bus.wr_rdy !== 1'b1) begin bad++; $display("FAIL rand_wr_rdy cyc=%0d got=0 exp=1", c); end
        exp_q.push_back(b);
        acc++;
        do_write(b);
      end else begin
        @(negedge ifclk);
      end
    end
    wait_drain(base + acc, ok);
    total++; if (!ok) begin bad++; $display("FAIL rand_drain_timeout got=%0d exp=%0d", we_cnt - base, acc); end
    e = order_err();
    total++; if (e !== -1) begin bad++; $display("FAIL rand_order err=%0d exp=-1", e); end
    total++; if (proto_bad !== 0) begin bad++; $display("FAIL launch_protocol got=%0d exp=0", proto_bad); end
  endtask

  initial begin
    bus.wr = 1'b0;
    bus.wr_data = 8'h00;
    test_reset();
    test_single();
    test_fill_order();
    test_overflow_clear();
    test_push_pop_full();
    test_cts();
    test_reset_mid();
    test_random_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit-side byte buffer between the DI byte unpacker and the `uart_duplex` transmitter. It accepts bytes at interface rate, stores up to 2^LOG2_TX_BUFFER_LEN of them, and feeds them one at a time to the serializer. Optional CTS hardware flow control gates when each byte starts. With this buffer, DI writes to the UART terminal no longer stall for every byte on `tx_busy`.

## Interface
- LOG2_TX_BUFFER_LEN, 4, log2 of FIFO depth (depth D = 2^N bytes, all usable)
- ifclk  in  1  system clock; all logic on rising edge
- resetb  in  1  reset, asynchronous, active-low
- wr  in  1  upstream byte write strobe
- wr_data  in  8  byte to enqueue, sampled when wr=1
- wr_rdy  out  1  FIFO not full (combinational from count)
- clear_tx_buffer  in  1  synchronous flush of queued bytes
- cts_en  in  1  1 = honour cts_n; 0 = ignore it
- cts_n  in  1  asynchronous clear-to-send from the pin, active-low
- uart_we  out  1  one-cycle start strobe to the transmitter
- uart_tx_data  out  8  byte for the transmitter; held stable from uart_we until the next uart_we
- uart_tx_busy  in  1  transmitter busy
- uart_tx_done  in  1  one-cycle pulse at the end of the stop bit
- tx_level  out  N+1  bytes queued, excluding the byte in flight
- tx_empty  out  1  tx_level==0 and FSM in IDLE
- tx_overflow  out  1  sticky: a write was attempted while full

## Operation
- Storage: D×8 RAM, rp/wp of N bits wrapping modulo D, count of N+1 bits. full = (count==D); empty = (count==0).
- Push: accepted when wr && !full && !clear_tx_buffer; writes mem[wp], wp+1.
- Write while full: byte dropped, tx_overflow<=1. Nothing else changes.
- Pop: the FSM launch. Reads mem[rp] into uart_tx_data, rp+1.
- Simultaneous push and pop: count unchanged. Both pointers advance.
- clear_tx_buffer: rp=wp=count=0 and tx_overflow=0. A write in the same cycle is dropped without setting overflow. A byte already in flight is not aborted.
- CTS: cts_n passes through a 2-flop synchronizer to give cts_ok = !cts_en || !cts_n_sync. cts_ok gates only the launch of a new byte.
- FSM states:
  - IDLE: go to SEND when !empty && !uart_tx_busy && cts_ok. The same edge pops, loads uart_tx_data, and sets uart_we for one cycle.
  - SEND: return to IDLE on uart_tx_done. Ignore all other inputs, including clear.
- At most one launch per transmitted byte. uart_we is never asserted in SEND.

## Timing
- Reset values: uart_we=0, uart_tx_data=0, tx_level=0, tx_empty=1, tx_overflow=0, wr_rdy=1, FSM=IDLE, pointers=0, CTS synchronizer=1 (not clear).
- Write latency: write sampled at edge E0 into an empty, idle buffer with cts_ok=1 → uart_we high in the cycle after edge E2 (2 clocks).
- Back-to-back: uart_tx_done sampled at edge T0 → FSM in IDLE after T0. If the FIFO is non-empty, the next uart_we is high after edge T1.
- wr_rdy: falls in the cycle after the push that makes count=D. Rises in the cycle after the next pop.
- CTS latency: a cts_n change takes effect 2 edges later. Deassertion during SEND does not stop the current byte; it blocks the next launch.
- tx_level and tx_empty are registered, consistent with the count after each edge.
- Reset mid-transfer: all state returns to reset values immediately. The transmitter's own reset aborts the serial byte.

## Test plan
- Single byte: write 0xA5 into an idle buffer with cts_en=0 → uart_we exactly one cycle, 2 clocks after the write, with uart_tx_data=0xA5. Then tx_empty=1 after the model's tx_done.
- Fill and order (N=4): write 0x00..0x0F back-to-back while the transmitter model is held busy → wr_rdy=0 after 16 writes and tx_level=16. Release the transmitter → serial output order is 0x00..0x0F, exactly 16 uart_we pulses.
- Overflow and clear: write 17 bytes with the transmitter held busy → 17th dropped, tx_overflow=1. Pulse clear_tx_buffer → tx_level=0, tx_overflow=0, no further uart_we.
- Push and pop in the same cycle at count=D: wr=1 on the launch edge → write rejected (full), overflow=1. Then, with count=D-1, push and pop in the same cycle → tx_level unchanged.
- CTS: cts_en=1, cts_n=1, queue 3 bytes → no uart_we. Drive cts_n=0 → first uart_we 2 edges after synchronizer capture. Drive cts_n=1 mid-byte → current byte completes, next byte held.
- Reset: assert resetb=0 while in SEND with 5 bytes queued → all outputs at reset values asynchronously. After release, no uart_we until a new write.
